// File: rtl/seg_scan_ctrl.sv
// Three-digit seven-segment scan controller: double-buffered code input, one digit lit at a time
// with blanking gaps. Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading '0' digits).
module seg_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] code_in,
    input  logic        code_vld,
    output logic        code_rdy,
    output logic [7:0]  seg,
    output logic [2:0]  dig_en,
    output logic        frame_done
);

    localparam int MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] SCAN_LOAD  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ON0,
        S_GAP0,
        S_ON1,
        S_GAP1,
        S_ON2,
        S_GAP2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [23:0]   active, active_nxt;
    logic [23:0]   pend;
    logic          pend_full, pend_full_nxt;
    logic          accept;
    logic          swap;
    logic          frame_end;
    logic [7:0]    seg_nxt;
    logic [2:0]    dig_nxt;

    assign code_rdy = ~pend_full;
    assign accept   = code_vld & ~pend_full;

    // Next-state sequencing; the shared counter reloads whenever the state changes.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        swap      = 1'b0;
        frame_end = 1'b0;
        case (state)
            S_IDLE: begin
                if (pend_full) begin
                    swap      = 1'b1;
                    state_nxt = S_ON0;
                    cnt_nxt   = SCAN_LOAD;
                end
            end
            S_ON0, S_GAP0, S_ON1, S_GAP1, S_ON2, S_GAP2: begin
                if (cnt == '0) begin
                    case (state)
                        S_ON0:   begin state_nxt = S_GAP0; cnt_nxt = BLANK_LOAD; end
                        S_GAP0:  begin state_nxt = S_ON1;  cnt_nxt = SCAN_LOAD;  end
                        S_ON1:   begin state_nxt = S_GAP1; cnt_nxt = BLANK_LOAD; end
                        S_GAP1:  begin state_nxt = S_ON2;  cnt_nxt = SCAN_LOAD;  end
                        S_ON2:   begin state_nxt = S_GAP2; cnt_nxt = BLANK_LOAD; end
                        default: begin
                            state_nxt = S_ON0;
                            cnt_nxt   = SCAN_LOAD;
                            frame_end = 1'b1;
                            swap      = pend_full;
                        end
                    endcase
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Swap and accept are mutually exclusive: a swap needs a full buffer, an accept an empty one.
    always_comb begin
        active_nxt    = active;
        pend_full_nxt = pend_full;
        if (swap) begin
            active_nxt    = pend;
            pend_full_nxt = 1'b0;
        end else if (accept) begin
            pend_full_nxt = 1'b1;
        end
    end

    // Output decode from the upcoming state so seg/dig_en switch on the same edge as the FSM.
    always_comb begin
        seg_nxt = 8'h00;
        dig_nxt = 3'b000;
`ifdef LEADING_ZERO_BLANK_EN
        case (state_nxt)
            S_ON0: begin
                dig_nxt = 3'b001;
                seg_nxt = active_nxt[7:0];
            end
            S_ON1: begin
                dig_nxt = 3'b010;
                seg_nxt = (active_nxt[23:16] == 8'hfc && active_nxt[15:8] == 8'hfc)
                          ? 8'h00 : active_nxt[15:8];
            end
            S_ON2: begin
                dig_nxt = 3'b100;
                seg_nxt = (active_nxt[23:16] == 8'hfc) ? 8'h00 : active_nxt[23:16];
            end
            default: begin
                seg_nxt = 8'h00;
                dig_nxt = 3'b000;
            end
        endcase
`else
        case (state_nxt)
            S_ON0: begin
                dig_nxt = 3'b001;
                seg_nxt = active_nxt[7:0];
            end
            S_ON1: begin
                dig_nxt = 3'b010;
                seg_nxt = active_nxt[15:8];
            end
            S_ON2: begin
                dig_nxt = 3'b100;
                seg_nxt = active_nxt[23:16];
            end
            default: begin
                seg_nxt = 8'h00;
                dig_nxt = 3'b000;
            end
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            active     <= 24'h0;
            pend       <= 24'h0;
            pend_full  <= 1'b0;
            seg        <= 8'h00;
            dig_en     <= 3'b000;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            active     <= active_nxt;
            pend_full  <= pend_full_nxt;
            if (accept) begin
                pend <= code_in;
            end
            seg        <= seg_nxt;
            dig_en     <= dig_nxt;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected per-cycle display frames are queued when a code
// is handed over and popped one per clock as the display scans.
module tb_seg_scan_ctrl;

    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 1;
    localparam int FRAME_LEN = 3 * (SCAN_DIV + BLANK_CYC);

    logic        clk;
    logic        rst;
    logic [23:0] code_in;
    logic        code_vld;
    logic        code_rdy;
    logic [7:0]  seg;
    logic [2:0]  dig_en;
    logic        frame_done;

    typedef struct {
        logic [7:0] seg;
        logic [2:0] dig;
        logic       fd;
    } exp_t;

    exp_t expQ[$];
    int   numChecks;
    int   numFails;

    seg_scan_ctrl #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .code_vld   (code_vld),
        .code_rdy   (code_rdy),
        .seg        (seg),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        numChecks++;
        if (obs !== expv) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Queue one full frame of expected display cycles for a code.
    task automatic pushFrame(input logic [23:0] code, input logic fdFirst);
        exp_t e;
        logic [7:0] s;
        for (int d = 0; d < 3; d++) begin
            s = code[8*d +: 8];
`ifdef LEADING_ZERO_BLANK_EN
            if (d == 2 && code[23:16] == 8'hfc) s = 8'h00;
            if (d == 1 && code[23:16] == 8'hfc && code[15:8] == 8'hfc) s = 8'h00;
`endif
            for (int i = 0; i < SCAN_DIV; i++) begin
                e.seg = s;
                e.dig = 3'(1 << d);
                e.fd  = (d == 0 && i == 0) ? fdFirst : 1'b0;
                expQ.push_back(e);
            end
            for (int i = 0; i < BLANK_CYC; i++) begin
                e.seg = 8'h00;
                e.dig = 3'b000;
                e.fd  = 1'b0;
                expQ.push_back(e);
            end
        end
    endtask

    // Advance n clocks; sample 1 time unit after each edge and score against the queue.
    task automatic applyStimulus(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("seg", 32'(seg), 32'(e.seg));
                checkOutput("dig_en", 32'(dig_en), 32'(e.dig));
                checkOutput("frame_done", 32'(frame_done), 32'(e.fd));
            end
        end
    endtask

    task automatic checkDark(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, "_dig"}, 32'(dig_en), 32'd0);
            checkOutput({tag, "_seg"}, 32'(seg), 32'd0);
            checkOutput({tag, "_fd"}, 32'(frame_done), 32'd0);
            checkOutput({tag, "_rdy"}, 32'(code_rdy), 32'd1);
        end
    endtask

    // Hand a code over from IDLE and queue its first frame.
    task automatic startFromIdle(input logic [23:0] code);
        code_in  = code;
        code_vld = 1'b1;
        checkOutput("idle_rdy", 32'(code_rdy), 32'd1);
        @(posedge clk);
        #1;
        code_vld = 1'b0;
        checkOutput("accept_rdy_low", 32'(code_rdy), 32'd0);
        checkOutput("accept_still_dark", 32'(dig_en), 32'd0);
        pushFrame(code, 1'b0);
    endtask

    initial begin
        numChecks = 0;
        numFails  = 0;
        rst       = 1'b0;
        code_in   = 24'h0;
        code_vld  = 1'b0;
        #1;
        checkOutput("rst_seg", 32'(seg), 32'd0);
        checkOutput("rst_dig", 32'(dig_en), 32'd0);
        checkOutput("rst_rdy", 32'(code_rdy), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Idle with nothing offered: stays dark, never pulses frame_done.
        checkDark("idle", 20);

        // "321" shown for two frames.
        startFromIdle(24'hf2da60);
        applyStimulus(FRAME_LEN);
        pushFrame(24'hf2da60, 1'b1);
        applyStimulus(3);

        // Mid-frame offer is buffered; the current frame finishes untouched.
        code_in  = 24'hfcfcb6;
        code_vld = 1'b1;
        checkOutput("mid_offer_rdy", 32'(code_rdy), 32'd1);
        applyStimulus(1);
        code_vld = 1'b0;
        checkOutput("mid_accepted_rdy", 32'(code_rdy), 32'd0);
        applyStimulus(FRAME_LEN - 4);
        checkOutput("rdy_before_swap", 32'(code_rdy), 32'd0);
        pushFrame(24'hfcfcb6, 1'b1);
        applyStimulus(1);
        checkOutput("rdy_after_swap", 32'(code_rdy), 32'd1);

        // Held offer while the buffer is full is taken only after the next swap.
        applyStimulus(1);
        code_in  = 24'h123456;
        code_vld = 1'b1;
        applyStimulus(1);
        checkOutput("c_accepted", 32'(code_rdy), 32'd0);
        code_in = 24'hfc60fc;
        applyStimulus(FRAME_LEN - 3);
        checkOutput("d_held", 32'(code_rdy), 32'd0);
        pushFrame(24'h123456, 1'b1);
        applyStimulus(1);
        checkOutput("d_window", 32'(code_rdy), 32'd1);
        applyStimulus(1);
        code_vld = 1'b0;
        checkOutput("d_accepted", 32'(code_rdy), 32'd0);
        applyStimulus(FRAME_LEN - 2);
        pushFrame(24'hfc60fc, 1'b1);
        applyStimulus(FRAME_LEN);

        // Reset during ON1 with a code pending: dark at once, pending code lost.
        pushFrame(24'hfc60fc, 1'b1);
        applyStimulus(1);
        code_in  = 24'hb6b6b6;
        code_vld = 1'b1;
        applyStimulus(1);
        code_vld = 1'b0;
        checkOutput("e_pending", 32'(code_rdy), 32'd0);
        applyStimulus(SCAN_DIV + BLANK_CYC);
        checkOutput("in_on1", 32'(dig_en), 32'd2);
        rst = 1'b0;
        #1;
        checkOutput("midrst_dig", 32'(dig_en), 32'd0);
        checkOutput("midrst_seg", 32'(seg), 32'd0);
        checkOutput("midrst_rdy", 32'(code_rdy), 32'd1);
        expQ.delete();
        @(negedge clk);
        rst = 1'b1;
        checkDark("post_rst", 8);

        // Leading-digit patterns from IDLE.
        startFromIdle(24'hfcfcb6);
        applyStimulus(FRAME_LEN);
        code_in  = 24'hfc60fc;
        code_vld = 1'b1;
        applyStimulus(1);
        code_vld = 1'b0;
        applyStimulus(FRAME_LEN - 1);
        pushFrame(24'hfc60fc, 1'b1);
        pushFrame(24'hfc60fc, 1'b1);
        applyStimulus(2 * FRAME_LEN);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
